// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl
//   Instruction-fetch controller. Owns the fetch PC, drives the combinational
//   instruction memory read address, and captures each returned word together
//   with its PC into a 2-entry queue drained by decode over valid/ready.
//   Execute can redirect fetch, which flushes the queue.
//
// Ports
//   clk, reset        : system clock, synchronous active-high reset
//   fetch_en          : allow fetching (PC advance + queue push)
//   imem_ra / imem_rd : instruction memory read address / combinational data
//   redirect_valid/pc : taken branch/jump target from execute
//   out_valid/ready   : decode handshake on the queue head
//   out_instr/out_pc  : queue head instruction and its byte address
//   q_count           : queue occupancy (0..2)
module imem_fetch_ctrl #(
    parameter int                     INS_ADDRESS = 9,
    parameter int                     INS_W       = 32,
    parameter logic [INS_ADDRESS-1:0] RESET_PC    = '0
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   fetch_en,
    output logic [INS_ADDRESS-1:0] imem_ra,
    input  logic [INS_W-1:0]       imem_rd,
    input  logic                   redirect_valid,
    input  logic [INS_ADDRESS-1:0] redirect_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [INS_W-1:0]       out_instr,
    output logic [INS_ADDRESS-1:0] out_pc,
    output logic [1:0]             q_count
);

    logic [INS_ADDRESS-1:0]        pc;
    logic [1:0][INS_W-1:0]         q_instr;
    logic [1:0][INS_ADDRESS-1:0]   q_pc;
    logic                          rd_ptr;
    logic                          wr_ptr;
    logic [1:0]                    count;
    logic                          pop;
    logic                          push;

    assign pop  = out_valid & out_ready;
    // A full queue can still take a word when the head leaves this cycle.
    assign push = fetch_en & ~redirect_valid & ((count < 2'd2) | pop);

    // imem_ra comes straight from the PC register: no combinational path
    // from the handshake or redirect inputs to the memory address.
    assign imem_ra   = pc;
    assign out_valid = (count != 2'd0);
    assign out_instr = q_instr[rd_ptr];
    assign out_pc    = q_pc[rd_ptr];
    assign q_count   = count;

    always_ff @(posedge clk) begin
        if (reset) begin
            pc      <= RESET_PC;
            q_instr <= '0;
            q_pc    <= '0;
            rd_ptr  <= 1'b0;
            wr_ptr  <= 1'b0;
            count   <= 2'd0;
        end else if (redirect_valid) begin
            // Any head popped this cycle is already consumed; the rest is dropped.
            pc     <= {redirect_pc[INS_ADDRESS-1:2], 2'b00};
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) begin
                q_instr[wr_ptr] <= imem_rd;
                q_pc[wr_ptr]    <= pc;
                wr_ptr          <= ~wr_ptr;
                pc              <= pc + INS_ADDRESS'(4);
            end
            if (pop)
                rd_ptr <= ~rd_ptr;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
module tb_imem_fetch_ctrl;

    localparam int AW = 9;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          fetch_en;
    logic [AW-1:0] imem_ra;
    logic [DW-1:0] imem_rd;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_instr;
    logic [AW-1:0] out_pc;
    logic [1:0]    q_count;

    always #5 clk = ~clk;

    imem_fetch_ctrl #(.INS_ADDRESS(AW), .INS_W(DW), .RESET_PC('0)) dut (
        .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_ra(imem_ra),
        .imem_rd(imem_rd), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc), .q_count(q_count)
    );

    // Instruction memory: word-addressed array, read combinationally.
    logic [DW-1:0] mem [128];
    assign imem_rd = mem[imem_ra[AW-1:2]];

    // Reference model: fetch PC plus an in-order list of fetched words.
    typedef struct { logic [DW-1:0] instr; logic [AW-1:0] pc; } ent_t;
    ent_t          mq[$];
    logic [AW-1:0] m_pc;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_model();
        chk("imem_ra", 64'(imem_ra), 64'(m_pc));
        chk("q_count", 64'(q_count), 64'(mq.size()));
        chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_instr", 64'(out_instr), 64'(mq[0].instr));
            chk("out_pc", 64'(out_pc), 64'(mq[0].pc));
        end
    endtask

    // Drive one cycle of inputs, advance the model, clock, then check at negedge.
    task automatic cyc(input logic r, input logic en, input logic rv,
                       input logic [AW-1:0] rpc, input logic rdy);
        bit   pop, push;
        ent_t e;
        reset = r; fetch_en = en; redirect_valid = rv; redirect_pc = rpc; out_ready = rdy;
        if (r) begin
            m_pc = '0;
            mq.delete();
        end else if (rv) begin
            m_pc = {rpc[AW-1:2], 2'b00};
            mq.delete();
        end else begin
            pop  = (mq.size() != 0) && rdy;
            push = en && ((mq.size() < 2) || pop);
            if (pop) void'(mq.pop_front());
            if (push) begin
                e.instr = mem[m_pc[AW-1:2]];
                e.pc    = m_pc;
                mq.push_back(e);
                m_pc = m_pc + AW'(4);
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk_model();
    endtask

    initial begin
        for (int i = 0; i < 128; i++) mem[i] = $urandom;
        mem[0] = 32'h0000_7033;
        mem[1] = 32'h0010_0093;
        mem[2] = 32'h0040_8213;
        m_pc = '0;

        // Reset state
        cyc(1, 0, 0, '0, 0);
        chk("rst_out_instr", 64'(out_instr), 64'h0);
        chk("rst_out_pc", 64'(out_pc), 64'h0);

        // Stream three words with decode always ready
        cyc(0, 1, 0, '0, 1);
        chk("stream0_instr", 64'(out_instr), 64'h0000_7033);
        cyc(0, 1, 0, '0, 1);
        chk("stream1_instr", 64'(out_instr), 64'h0010_0093);
        cyc(0, 1, 0, '0, 1);
        chk("stream2_pc", 64'(out_pc), 64'h008);

        // Backpressure after reset: fills in two cycles then stalls at 0x008
        cyc(1, 0, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, 0);
        chk("bp_ra", 64'(imem_ra), 64'h008);
        chk("bp_head", 64'(out_pc), 64'h000);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, '0, 1);
        cyc(0, 1, 0, '0, 0);   // refill to full

        // Redirect with a full queue
        chk("pre_redir_full", 64'(q_count), 64'd2);
        cyc(0, 1, 1, 9'h027, 0);
        chk("redir_ra", 64'(imem_ra), 64'h024);
        chk("redir_valid", 64'(out_valid), 64'd0);
        cyc(0, 1, 0, '0, 1);
        chk("redir_head", 64'(out_pc), 64'h024);

        // Wrap-around of the PC
        cyc(0, 1, 1, 9'h1FC, 1);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, 1);

        // fetch_en low: PC holds while the queue drains
        cyc(0, 1, 0, '0, 0);
        cyc(0, 1, 0, '0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0, 1);
        chk("hold_empty", 64'(q_count), 64'd0);

        // Full queue with simultaneous push and pop
        cyc(0, 1, 0, '0, 0);
        cyc(0, 1, 0, '0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, 0, '0, 1);

        // Reset mid-operation dominates redirect
        cyc(0, 1, 0, '0, 0);
        cyc(0, 1, 0, '0, 0);
        cyc(1, 1, 1, 9'h100, 1);
        chk("midrst_ra", 64'(imem_ra), 64'h000);
        chk("midrst_instr", 64'(out_instr), 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++)
            cyc(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 9) == 0), AW'($urandom), ($urandom_range(0, 2) != 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imem_fetch_ctrl.md
# imem_fetch_ctrl

Instruction-fetch controller that sequences the combinational instruction memory for the pipelined RISC-V core. It owns the fetch PC and drives the instruction memory read address. Each returned word is captured, together with its PC, into a 2-entry fetch queue. The decode stage drains the queue through a valid/ready handshake, and execute can redirect fetch on taken branches and jumps (flushing the queue).

## Interface
- INS_ADDRESS, 9, byte-address width of the instruction memory (same as the memory's read-address width)
- INS_W, 32, instruction width
- RESET_PC, 0, fetch PC after reset; must be word-aligned

- clk  in  1  single system clock, all state on rising edge
- reset  in  1  synchronous, active-high; sampled on rising edge of clk
- fetch_en  in  1  1 = fetching allowed; 0 = hold PC, no pushes (queue still drains)
- imem_ra  out  INS_ADDRESS  read address to instruction memory; always equals the PC register
- imem_rd  in  INS_W  combinational read data from instruction memory for imem_ra
- redirect_valid  in  1  taken branch/jump from execute; one-cycle pulse
- redirect_pc  in  INS_ADDRESS  redirect target byte address; bits [1:0] ignored
- out_valid  out  1  queue head holds a valid instruction
- out_ready  in  1  decode accepts the head this cycle
- out_instr  out  INS_W  instruction at queue head
- out_pc  out  INS_ADDRESS  byte address of out_instr
- q_count  out  2  entries currently in queue (0..2)

## Operation
- State:
  - PC register.
  - 2-entry circular queue (instr + pc per entry).
  - 1-bit rd_ptr and 1-bit wr_ptr.
  - 2-bit count.
- pop = out_valid & out_ready.
- push = fetch_en & ~redirect_valid & (count < 2 | pop).
  - A full queue with a simultaneous pop accepts a push.
- On push:
  - The entry at wr_ptr <= {imem_rd, PC}.
  - wr_ptr toggles.
  - PC <= PC + 4, truncated to INS_ADDRESS bits.
  - Wrap-around: PC goes from 2^INS_ADDRESS-4 to 0.
- On pop: rd_ptr toggles.
- count update: count + push - pop.
- out_valid = (count != 0). out_instr and out_pc are driven from the entry at rd_ptr.
- Redirect (redirect_valid = 1) takes priority over everything:
  - PC <= {redirect_pc[INS_ADDRESS-1:2], 2'b00}.
  - count <= 0, rd_ptr <= 0, wr_ptr <= 0.
  - No push that cycle.
  - A head accepted in the same cycle (pop = 1) counts as consumed by decode. All remaining entries are discarded.
- fetch_en = 0:
  - PC and wr_ptr hold.
  - Pops continue normally.
  - A redirect is still honored.
- Reset (any cycle, including mid-fetch or with a full queue):
  - PC <= RESET_PC.
  - count, rd_ptr and wr_ptr <= 0.
  - All queue storage <= 0.
  - Reset dominates redirect_valid, fetch_en and out_ready.
- Outputs after reset:
  - out_valid = 0, out_instr = 0, out_pc = 0, q_count = 0.
  - imem_ra = RESET_PC.
- No combinational path from out_ready or redirect_valid to imem_ra. imem_ra changes only at clock edges.

## Timing
- Fetch latency:
  - PC is presented on imem_ra in cycle N.
  - The word is written to the queue at the end of cycle N.
  - out_valid/out_instr are visible in cycle N+1.
- Sustained throughput is 1 instruction/cycle when out_ready = 1 continuously.
- Redirect asserted in cycle N:
  - imem_ra = target in cycle N+1.
  - The target instruction appears on out_* in cycle N+2.
  - out_valid = 0 in cycle N+1 (one bubble).
- Backpressure:
  - With out_ready = 0, the queue fills in 2 cycles, then PC stalls.
  - The stalled PC is the address of the next unfetched word; no word is skipped or duplicated.
- out_instr/out_pc are stable while out_valid = 1 and out_ready = 0.

## Test plan
- Reset then stream:
  - Stimulus: memory holds 0x00007033 @0, 0x00100093 @4, 0x00408213 @8; out_ready = 1.
  - Response: out_* in cycles 1, 2, 3 = (0x00007033, 0x000), (0x00100093, 0x004), (0x00408213, 0x008).
- Backpressure:
  - Stimulus: out_ready = 0 for 4 cycles after reset.
  - Response: q_count goes 1, 2, 2, 2. imem_ra holds at 0x008. out_pc stays 0x000.
  - Then set out_ready = 1: PCs 0x000, 0x004, 0x008 emerge in order, with no gap and no duplicate.
- Redirect with full queue:
  - Stimulus: queue full, redirect_valid = 1, redirect_pc = 0x027.
  - Response: next cycle q_count = 0, out_valid = 0, imem_ra = 0x024. The following cycle out_pc = 0x024.
- Wrap-around:
  - Stimulus: redirect to 0x1FC, stream.
  - Response: out_pc sequence 0x1FC, 0x000, 0x004.
- fetch_en hold plus simultaneous push/pop on full queue:
  - fetch_en = 0 for 3 cycles: imem_ra is constant and q_count only decrements.
  - Full queue with out_ready = 1 and fetch_en = 1: q_count stays 2 and PC advances by 4 each cycle.
- Reset mid-operation:
  - Stimulus: assert reset with q_count = 2 and redirect_valid = 1.
  - Response: next cycle imem_ra = RESET_PC, q_count = 0, out_valid = 0, out_instr = 0.
